// File: rtl/lsu_controller_pkg.sv
// Shared types and lane helpers for the RV32I load/store sequencer.
// Trap cause encodings match the core's trap unit.
package lsu_controller_pkg;

    localparam int XLEN   = 32;
    localparam int STRB_W = XLEN / 8;

    typedef enum logic [2:0] {
        LSU_IDLE   = 3'd0,
        LSU_CHECK  = 3'd1,
        LSU_ISSUE  = 3'd2,
        LSU_WAIT_R = 3'd3,
        LSU_RESP   = 3'd4
    } lsu_state_e;

    typedef enum logic [3:0] {
        TRAP_NONE                      = 4'b0000,
        TRAP_ILLEGAL_INSTRUCTION       = 4'b0101,
        TRAP_MEMORY_ADDRESS_MISALIGNED = 4'b0110
    } trap_cause_e;

    typedef enum logic [2:0] {
        SX_0700  = 3'd0,
        SXU_0700 = 3'd1,
        SX_1500  = 3'd2,
        SXU_1500 = 3'd3,
        SX_3100  = 3'd4
    } sx_ops_e;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_NONE = 2'b11
    } mem_access_type_e;

    // MEM_NONE marks a funct3 that is not a legal access for the op kind.
    function automatic mem_access_type_e lsu_access_type(input logic is_store,
                                                         input logic [2:0] f3);
        mem_access_type_e t;
        t = MEM_NONE;
        case (f3)
            3'b000: t = MEM_BYTE;
            3'b001: t = MEM_HALF;
            3'b010: t = MEM_WORD;
            3'b100: t = is_store ? MEM_NONE : MEM_BYTE;
            3'b101: t = is_store ? MEM_NONE : MEM_HALF;
            default: t = MEM_NONE;
        endcase
        return t;
    endfunction

    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == 2'b01) && addr_lo[0]) || ((size == 2'b10) && (addr_lo != 2'b00));
    endfunction

    function automatic logic [STRB_W-1:0] lsu_wstrb(input logic [1:0] size,
                                                    input logic [1:0] addr_lo);
        logic [STRB_W-1:0] s;
        case (size)
            2'b00:   s = 4'b0001 << addr_lo;
            2'b01:   s = 4'b0011 << {addr_lo[1], 1'b0};
            default: s = 4'hF;
        endcase
        return s;
    endfunction

    function automatic logic [XLEN-1:0] lsu_wdata(input logic [1:0] size,
                                                  input logic [XLEN-1:0] d);
        logic [XLEN-1:0] w;
        case (size)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic sx_ops_e lsu_sx_op(input logic [2:0] f3);
        sx_ops_e op;
        case (f3)
            3'b000:  op = SX_0700;
            3'b100:  op = SXU_0700;
            3'b001:  op = SX_1500;
            3'b101:  op = SXU_1500;
            default: op = SX_3100;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/lsu_controller_load_align.sv
// Load lane extraction: shifts the addressed bytes down to bit 0 and
// sign/zero-extends according to funct3.
module lsu_controller_load_align
    import lsu_controller_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        result  = shifted;
        case (lsu_sx_op(funct3))
            SX_0700:  result = {{24{shifted[7]}}, shifted[7:0]};
            SXU_0700: result = {24'h0, shifted[7:0]};
            SX_1500:  result = {{16{shifted[15]}}, shifted[15:0]};
            SXU_1500: result = {16'h0, shifted[15:0]};
            default:  result = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_controller.sv
// Load/store sequencer between the execute stage and the data-memory bus.
// state  | meaning
// IDLE   | ready for a new op
// CHECK  | funct3 legality / alignment check of the captured op
// ISSUE  | bus request held until bus_ready
// WAIT_R | load accepted, waiting for bus_rvalid
// RESP   | one-cycle completion to the core (suppressed when dropped)
module lsu_controller
    import lsu_controller_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_trap,
    output logic [3:0]        resp_cause,
    output logic [XLEN-1:0]   resp_tval,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [STRB_W-1:0] bus_wstrb,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_rdata
);

    lsu_state_e      state_q, state_d;
    logic            is_store_q, is_store_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            trap_q, trap_d;
    trap_cause_e     cause_q, cause_d;
    logic            drop_q, drop_d;

    logic            accept;
    logic [XLEN-1:0] load_result;

    lsu_controller_load_align u_load_align (
        .rdata   (bus_rdata),
        .addr_lo (addr_q[1:0]),
        .funct3  (funct3_q),
        .result  (load_result)
    );

    assign req_ready = (state_q == LSU_IDLE) && !flush;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        trap_d     = trap_q;
        cause_d    = cause_q;
        drop_d     = drop_q;

        case (state_q)
            LSU_IDLE: begin
                if (accept) begin
                    is_store_d = req_is_store;
                    funct3_d   = req_funct3;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    rdata_d    = '0;
                    trap_d     = 1'b0;
                    cause_d    = TRAP_NONE;
                    state_d    = LSU_CHECK;
                end
            end
            LSU_CHECK: begin
                if (flush) begin
                    state_d = LSU_IDLE;
                end else if (lsu_access_type(is_store_q, funct3_q) == MEM_NONE) begin
                    trap_d  = 1'b1;
                    cause_d = TRAP_ILLEGAL_INSTRUCTION;
                    state_d = LSU_RESP;
                end else if (lsu_misaligned(funct3_q[1:0], addr_q[1:0])) begin
                    trap_d  = 1'b1;
                    cause_d = TRAP_MEMORY_ADDRESS_MISALIGNED;
                    state_d = LSU_RESP;
                end else begin
                    state_d = LSU_ISSUE;
                end
            end
            LSU_ISSUE: begin
                // A flush cannot abandon a posted request; finish it silently.
                if (flush) drop_d = 1'b1;
                if (bus_ready) state_d = is_store_q ? LSU_RESP : LSU_WAIT_R;
            end
            LSU_WAIT_R: begin
                if (flush) drop_d = 1'b1;
                if (bus_rvalid) begin
                    rdata_d = load_result;
                    state_d = LSU_RESP;
                end
            end
            LSU_RESP: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase

        if (state_d == LSU_IDLE) drop_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LSU_IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            trap_q     <= 1'b0;
            cause_q    <= TRAP_NONE;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            trap_q     <= trap_d;
            cause_q    <= cause_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        resp_valid = (state_q == LSU_RESP) && !drop_q && !flush;
        resp_rdata = '0;
        resp_trap  = 1'b0;
        resp_cause = TRAP_NONE;
        resp_tval  = '0;
        if (resp_valid) begin
            resp_trap  = trap_q;
            resp_cause = cause_q;
            resp_rdata = trap_q ? '0 : rdata_q;
            resp_tval  = (cause_q == TRAP_MEMORY_ADDRESS_MISALIGNED) ? addr_q : '0;
        end

        bus_valid = (state_q == LSU_ISSUE);
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_wstrb = '0;
        if (bus_valid) begin
            bus_we   = is_store_q;
            bus_addr = {addr_q[XLEN-1:2], 2'b00};
            if (is_store_q) begin
                bus_wdata = lsu_wdata(funct3_q[1:0], wdata_q);
                bus_wstrb = lsu_wstrb(funct3_q[1:0], addr_q[1:0]);
            end
        end
    end

endmodule
